// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - datapath/control bundle for the multicycle control unit
//
// Purpose: groups the instruction fields, ALU flags, memory handshake and all
// datapath control strobes exchanged between the datapath and the control unit.
// Ports (signals):
//   Instr[31:12]  instruction fields (cond, Op, Funct, Rd)
//   ALUFlags[3:0] {N,Z,C,V} from the datapath ALU
//   MemReady      memory access complete
//   PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc[1:0],
//   ALUSrcA, ALUSrcB[1:0], ALUControl[ALUCTRL_W-1:0], ImmSrc[1:0],
//   RegSrc[1:0], Illegal, State[3:0]  control outputs
// Modports: master = datapath side, slave = control unit side.
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 2
);
    logic [31:12]          Instr;
    logic [3:0]            ALUFlags;
    logic                  MemReady;
    logic                  PCWrite;
    logic                  IRWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [ALUCTRL_W-1:0]  ALUControl;
    logic [1:0]            ImmSrc;
    logic [1:0]            RegSrc;
    logic                  Illegal;
    logic [3:0]            State;

    modport master (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Illegal, State
    );

    modport slave (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Illegal, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle ARM-subset control FSM
//
// Purpose: sequences FETCH/DECODE/execute/writeback for a small ARM subset
// (ADD, SUB, AND, ORR, CMP, LDR, STR, B), evaluates condition codes against
// an internal {N,Z,C,V} flag register and flags undecodable instructions.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    multicycle_control_unit_if.slave (instruction, flags, MemReady in;
//          datapath control strobes, Illegal and State out)
module multicycle_control_unit #(
    parameter int ALUCTRL_W   = 2,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    multicycle_control_unit_if.slave        bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_ORR = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;

    logic [3:0] cond_field;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_pc;
    logic       mem_ready;
    logic       unused_instr;

    assign cond_field   = bus.Instr[31:28];
    assign op           = bus.Instr[27:26];
    assign funct        = bus.Instr[25:20];
    assign cmd          = funct[4:1];
    assign s_bit        = funct[0];
    assign rd_pc        = (bus.Instr[15:12] == 4'hF);
    assign unused_instr = ^bus.Instr[19:16];
    assign mem_ready    = MEM_WAIT_EN ? bus.MemReady : 1'b1;

    // Condition evaluation against the stored flags (not the live ALU flags).
    logic cond_pass;
    logic fn, fz, fc, fv;
    assign {fn, fz, fc, fv} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond_field)
            4'h0: cond_pass = fz;
            4'h1: cond_pass = ~fz;
            4'h2: cond_pass = fc;
            4'h3: cond_pass = ~fc;
            4'h4: cond_pass = fn;
            4'h5: cond_pass = ~fn;
            4'h6: cond_pass = fv;
            4'h7: cond_pass = ~fv;
            4'h8: cond_pass = fc & ~fz;
            4'h9: cond_pass = ~fc | fz;
            4'hA: cond_pass = (fn == fv);
            4'hB: cond_pass = (fn != fv);
            4'hC: cond_pass = ~fz & (fn == fv);
            4'hD: cond_pass = fz | (fn != fv);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic cmd_known;
    logic illegal_dec;
    logic cv_cmd;
    logic [1:0] cmd_alu;

    always_comb begin
        cmd_known = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                    (cmd == CMD_ORR) || (cmd == CMD_CMP);
        illegal_dec = (op == 2'b11) ||
                      ((op == 2'b00) && (!cmd_known || ((cmd == CMD_CMP) && !s_bit)));
        // Logical ops leave carry/overflow alone.
        cv_cmd = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
        case (cmd)
            CMD_SUB, CMD_CMP: cmd_alu = ALU_SUB;
            CMD_AND:          cmd_alu = ALU_AND;
            CMD_ORR:          cmd_alu = ALU_ORR;
            default:          cmd_alu = ALU_ADD;
        endcase
    end

    logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
    logic       alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_ctrl;

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cond_d     = cond_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 1'b0;
        result_src = 2'd0;
        alu_src_b  = 2'd0;
        alu_ctrl   = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                cond_d     = cond_pass;
                // A failed condition squashes before decode legality is considered.
                if (!cond_pass) begin
                    state_d = S_FETCH;
                end else if (illegal_dec) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        2'b01:   state_d = S_MEMADR;
                        2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b = 2'd1;
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = cond_q;
                pc_write   = cond_q & rd_pc;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = cond_q;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b = (state_q == S_EXECI) ? 2'd1 : 2'd0;
                alu_ctrl  = cmd_alu;
                if (s_bit && cond_q) begin
                    flags_d[3:2] = bus.ALUFlags[3:2];
                    if (cv_cmd) flags_d[1:0] = bus.ALUFlags[1:0];
                end
                state_d = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = cond_q;
                pc_write  = cond_q & rd_pc;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                pc_write   = cond_q;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    // Write strobes are forced low for the whole reset cycle, whatever state we were in.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.Illegal    = illegal   & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = ALUCTRL_W'(alu_ctrl);
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.State      = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALUCTRL_W(2)) bus ();

    multicycle_control_unit #(.ALUCTRL_W(2), .MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       pcw;
        logic       irw;
        logic       adr;
        logic       memw;
        logic       regw;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] alu;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic       ill;
    } ctl_t;

    int checks = 0;
    int errors = 0;
    int n_regw = 0, n_memw = 0, n_ill = 0, n_pcw = 0, n_memread = 0;

    logic [31:0] cur_instr;
    logic [3:0]  mflags;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [31:0] ins);
        logic [3:0] cmd;
        cmd = ins[24:21];
        if (ins[27:26] == 2'b11) return 1'b1;
        if (ins[27:26] != 2'b00) return 1'b0;
        if (!(cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12 || cmd == 10)) return 1'b1;
        return (cmd == 10) && !ins[20];
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'd2, 4'd10: return 2'd1;
            4'd0:        return 2'd2;
            4'd12:       return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    // Expected outputs of one cycle, from the published per-state output table.
    function automatic ctl_t model_out(input int st, input logic mr, input logic rst);
        ctl_t e;
        logic [1:0] op;
        e = '0;
        op = cur_instr[27:26];
        e.state  = 4'(st);
        e.imm    = op;
        e.regsrc = {op == 2'b01, op == 2'b10};
        case (st)
            0: begin e.srca = 1; e.srcb = 2; e.res = 2; e.irw = mr; e.pcw = mr; end
            1: begin
                e.srca = 1; e.srcb = 2; e.res = 2;
                e.ill = cond_ok(cur_instr[31:28], mflags) && is_illegal(cur_instr);
            end
            2: e.srcb = 1;
            3: e.adr = 1;
            4: begin e.res = 1; e.regw = 1; e.pcw = (cur_instr[15:12] == 4'hF); end
            5: begin e.adr = 1; e.memw = 1; end
            6, 7: begin e.srcb = (st == 7) ? 2'd1 : 2'd0; e.alu = alu_code(cur_instr[24:21]); end
            8: begin e.regw = 1; e.pcw = (cur_instr[15:12] == 4'hF); end
            9: begin e.srcb = 1; e.res = 2; e.pcw = 1; end
            default: ;
        endcase
        if (rst) begin
            e.pcw = 0; e.irw = 0; e.regw = 0; e.memw = 0; e.ill = 0;
        end
        return e;
    endfunction

    task automatic check_cycle(input ctl_t e);
        ctl_t a;
        a = {bus.State, bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
             bus.RegSrc, bus.Illegal};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL ctl_cycle t=%0t instr=%h actual state=%0d vec=%h required state=%0d vec=%h",
                     $time, cur_instr, a.state, a, e.state, e);
        end
        n_regw    += int'(a.regw);
        n_memw    += int'(a.memw);
        n_ill     += int'(a.ill);
        n_pcw     += int'(a.pcw);
        n_memread += int'(a.state == 4'd3);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance.
    task automatic cyc(input int st, input logic mr, input logic [3:0] af, input logic rst);
        ctl_t e;
        bus.MemReady = mr;
        bus.ALUFlags = af;
        reset = rst;
        e = model_out(st, mr, rst);
        @(negedge clk);
        check_cycle(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fstall, input int mstall,
                             input int af_force, output int cycles);
        logic [3:0] afx;
        logic [3:0] cmd;
        cur_instr = ins;
        bus.Instr = ins[31:12];
        cmd = ins[24:21];
        cycles = 0;
        for (int i = 0; i < fstall; i++) begin cyc(0, 1'b0, 4'($urandom), 1'b0); cycles++; end
        cyc(0, 1'b1, 4'($urandom), 1'b0); cycles++;
        cyc(1, 1'($urandom), 4'($urandom), 1'b0); cycles++;
        if (!cond_ok(ins[31:28], mflags) || is_illegal(ins)) return;
        case (ins[27:26])
            2'b01: begin
                cyc(2, 1'($urandom), 4'($urandom), 1'b0); cycles++;
                if (ins[20]) begin
                    for (int i = 0; i < mstall; i++) begin cyc(3, 1'b0, 4'($urandom), 1'b0); cycles++; end
                    cyc(3, 1'b1, 4'($urandom), 1'b0); cycles++;
                    cyc(4, 1'($urandom), 4'($urandom), 1'b0); cycles++;
                end else begin
                    for (int i = 0; i < mstall; i++) begin cyc(5, 1'b0, 4'($urandom), 1'b0); cycles++; end
                    cyc(5, 1'b1, 4'($urandom), 1'b0); cycles++;
                end
            end
            2'b00: begin
                afx = (af_force >= 0) ? 4'(af_force) : 4'($urandom);
                cyc(ins[25] ? 7 : 6, 1'($urandom), afx, 1'b0); cycles++;
                if (ins[20]) begin
                    mflags[3:2] = afx[3:2];
                    if (cmd == 4 || cmd == 2 || cmd == 10) mflags[1:0] = afx[1:0];
                end
                if (cmd != 10) begin cyc(8, 1'($urandom), 4'($urandom), 1'b0); cycles++; end
            end
            default: begin
                cyc(9, 1'($urandom), 4'($urandom), 1'b0); cycles++;
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        logic [3:0]  tbl [5];
        int sel;
        tbl = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10};
        x = $urandom;
        sel = $urandom_range(0, 9);
        x[27:26] = (sel <= 5) ? 2'b00 : (sel <= 7) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
        if (x[27:26] == 2'b00 && $urandom_range(0, 7) != 0) x[24:21] = tbl[$urandom_range(0, 4)];
        if (x[24:21] == 4'd10 && $urandom_range(0, 3) != 0) x[20] = 1'b1;
        if ($urandom_range(0, 1) == 1) x[31:28] = 4'hE;
        return x;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cy, r0, m0, i0, p0, q0;
        reset = 1'b1;
        bus.Instr = '0;
        bus.ALUFlags = 4'b0000;
        bus.MemReady = 1'b1;
        cur_instr = 32'hE0821003;
        mflags = 4'b0000;
        @(posedge clk); #1;
        // Second reset cycle: FETCH with MemReady high must still be write-silent.
        @(negedge clk);
        check_int("reset_state", int'(bus.State), 0);
        check_int("reset_writes", int'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.Illegal}), 0);
        @(posedge clk); #1;
        cyc(0, 1'b0, 4'b0000, 1'b0);

        // ADD R1,R2,R3
        r0 = n_regw;
        run_instr(32'hE0821003, 0, 0, -1, cy);
        check_int("add_cycles", cy, 4);
        check_int("add_regwrite", n_regw - r0, 1);

        // CMP sets Z, ADDEQ executes; CMP clears Z, ADDEQ squashed
        run_instr(32'hE1510002, 0, 0, 4, cy);
        check_int("cmp_cycles", cy, 3);
        r0 = n_regw;
        run_instr(32'h00821003, 0, 0, -1, cy);
        check_int("addeq_taken_cycles", cy, 4);
        check_int("addeq_taken_regwrite", n_regw - r0, 1);
        run_instr(32'hE1510002, 0, 0, 0, cy);
        r0 = n_regw;
        run_instr(32'h00821003, 0, 0, -1, cy);
        check_int("addeq_squash_cycles", cy, 2);
        check_int("addeq_squash_regwrite", n_regw - r0, 0);

        // LDR with three wait cycles
        r0 = n_regw; q0 = n_memread;
        run_instr(32'hE5954004, 0, 3, -1, cy);
        check_int("ldr_cycles", cy, 8);
        check_int("ldr_memread_cycles", n_memread - q0, 4);
        check_int("ldr_regwrite", n_regw - r0, 1);

        // STR and B
        m0 = n_memw;
        run_instr(32'hE5854004, 0, 0, -1, cy);
        check_int("str_cycles", cy, 4);
        check_int("str_memwrite", n_memw - m0, 1);
        p0 = n_pcw;
        run_instr(32'hEA000002, 0, 0, -1, cy);
        check_int("b_cycles", cy, 3);
        check_int("b_pcwrite", n_pcw - p0, 2);

        // Illegal encodings
        i0 = n_ill; r0 = n_regw; m0 = n_memw;
        run_instr(32'hEC000000, 0, 0, -1, cy);
        check_int("op11_cycles", cy, 2);
        run_instr(32'hE0200000, 0, 0, -1, cy);
        run_instr(32'hE1400000, 0, 0, -1, cy);
        check_int("illegal_pulses", n_ill - i0, 3);
        check_int("illegal_no_writes", (n_regw - r0) + (n_memw - m0), 0);
        i0 = n_ill;
        run_instr(32'hF0821003, 0, 0, -1, cy);
        check_int("never_cycles", cy, 2);
        check_int("never_not_illegal", n_ill - i0, 0);

        // Reset in the middle of a stalled STR, with Z set beforehand
        run_instr(32'hE1510002, 0, 0, 4, cy);
        cur_instr = 32'hE5854004;
        bus.Instr = cur_instr[31:12];
        m0 = n_memw;
        cyc(0, 1'b1, 4'h0, 1'b0);
        cyc(1, 1'b1, 4'h0, 1'b0);
        cyc(2, 1'b1, 4'h0, 1'b0);
        cyc(5, 1'b0, 4'h0, 1'b0);
        cyc(5, 1'b0, 4'h0, 1'b0);
        cyc(5, 1'b0, 4'h0, 1'b1);
        mflags = 4'b0000;
        check_int("rst_memwrite_pulses", n_memw - m0, 2);
        r0 = n_regw;
        run_instr(32'h00821003, 0, 0, -1, cy);
        check_int("post_reset_addeq_cycles", cy, 2);
        check_int("post_reset_addeq_regwrite", n_regw - r0, 0);

        // Randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), -1, cy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 2, width of ALUControl (minimum 2).
REQ-002 SHALL have parameter MEM_WAIT_EN, default 1; when 0, MemReady is ignored and treated as 1.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Instr  in  [31:12]  cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from datapath ALU
- MemReady  in  1  memory access complete
- PCWrite  out  1  PC load enable
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=ALU result as memory address
- MemWrite  out  1  data memory write
- RegWrite  out  1  register file write
- ResultSrc  out  2  0=ALUOut reg, 1=read data, 2=ALU result
- ALUSrcA  out  1  0=Rn, 1=PC
- ALUSrcB  out  2  0=Rm, 1=ExtImm, 2=constant 4
- ALUControl  out  ALUCTRL_W  ADD=0, SUB=1, AND=2, ORR=3, zero-extended
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- Illegal  out  1  one-cycle pulse on undecodable instruction
- State  out  4  current state encoding (debug)

Function
REQ-004 SHALL implement the states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; all other encodings SHALL go to FETCH.
REQ-005 FETCH:
- Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ResultSrc=2.
- IRWrite=PCWrite=MemReady.
- Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
REQ-006 DECODE:
- Outputs: ALUSrcA=1, ALUSrcB=2, ResultSrc=2.
- Latches condition result CondQ from Instr[31:28] and the flag register.
- If CondQ=0, the instruction is squashed and the next state is FETCH, with no writes.
- Illegal encoding: next state FETCH and Illegal=1 for that cycle.
- Otherwise: Op=01 goes to MEMADR; Op=00 goes to EXECI if Funct[5]=1, else EXECR; Op=10 goes to BRANCH.
REQ-007 Illegal encodings are:
- Op=11.
- DP cmd not in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP}.
- CMP with S=0.
REQ-008 MEMADR: ALUSrcA=0, ALUSrcB=1, ALUControl=ADD; next state MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-009 MEMREAD: AdrSrc=1, ResultSrc=0; next state MEMWB on MemReady, else hold.
REQ-010 MEMWB: ResultSrc=1, RegWrite=1, PCWrite=(Rd==15); next state FETCH.
REQ-011 MEMWRITE: AdrSrc=1, MemWrite=1 while in state; next state FETCH on MemReady, else hold.
REQ-012 EXECR/EXECI:
- Outputs: ALUSrcA=0, ALUSrcB=0 (EXECR) or 1 (EXECI), ALUControl per cmd (CMP uses SUB).
- Next state FETCH for CMP, else ALUWB.
REQ-013 ALUWB: ResultSrc=0, RegWrite=1, PCWrite=(Rd==15); next state FETCH.
REQ-014 BRANCH: ALUSrcA=0, ALUSrcB=1, ALUControl=ADD, ResultSrc=2, PCWrite=1; next state FETCH.
REQ-015 In any state not listed above, each output SHALL be 0; ImmSrc and RegSrc SHALL be combinational from Op in all states.
REQ-016 Flag register {N,Z,C,V} SHALL update only at the clock edge ending EXECR/EXECI when S=1.
- NZ updates for all commands.
- CV updates only for ADD, SUB and CMP.
REQ-017 Conditions SHALL follow ARM encoding 0000 EQ through 1101 LE; 1110 is always true; 1111 is false (squashed).
REQ-018 Latency with MemReady=1 SHALL be:
- DP: 4 cycles.
- CMP: 3 cycles.
- LDR: 5 cycles.
- STR: 4 cycles.
- B: 3 cycles.
- Squashed or illegal: 2 cycles.

Reset
REQ-019 While reset=1:
- PCWrite, IRWrite, RegWrite, MemWrite and Illegal SHALL be 0.
- At the edge, State SHALL go to FETCH and flags to 0000.
REQ-020 Reset asserted in any state, including mid-wait in MEMREAD/MEMWRITE, SHALL abort the instruction, with FETCH the cycle after reset deasserts.

Verification
REQ-021 ADD R1,R2,R3 with cond=1110, S=0 -> FETCH/DECODE/EXECR/ALUWB; ALUControl=0 in EXECR; RegWrite=1 only in ALUWB; back in FETCH at cycle 5.
REQ-022 CMP (S=1) with ALUFlags=0100, then ADDEQ -> the ADDEQ executes; repeat with ALUFlags=0000 -> the ADDEQ leaves DECODE directly to FETCH with no RegWrite.
REQ-023 LDR with MemReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; RegWrite=1 in MEMWB only; total 8 cycles.
REQ-024 STR with MemReady=1 -> MemWrite=1 exactly one cycle (MEMWRITE); B -> PCWrite=1 in FETCH and BRANCH.
REQ-025 Op=11 -> Illegal=1 in DECODE; no write enable asserted; FETCH next.
REQ-026 Reset pulsed during MEMWRITE wait -> MemWrite=0 during reset; State=0 and flags=0000 afterward.
